// File: rtl/execute_muldiv_stage.sv
// Execute stage: single-cycle ALU plus iterative radix-2 multiply/divide.
// Multi-cycle ops (MUL, MULHU, DIV, DIVU, REM, REMU) hold the stage busy and
// stall upstream through in_ready. A forwarding record (rd, ready, data) is
// published for the hazard logic in earlier stages.
// Optional build macro MULDIV_EARLY_OUT_EN: MUL/MULHU leave the iteration
// phase as soon as the remaining multiplier bits are all zero.
module execute_muldiv_stage #(
   parameter int WIDTH        = 32,
   parameter int REG_ID_WIDTH = 5
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_pc,
   input  logic [31:0]             in_instruction,
   input  logic [3:0]              in_op,
   input  logic [WIDTH-1:0]        in_a,
   input  logic [WIDTH-1:0]        in_b,
   input  logic [REG_ID_WIDTH-1:0] in_rd,
   input  logic                    in_reg_write,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_pc,
   output logic [31:0]             out_instruction,
   output logic [REG_ID_WIDTH-1:0] out_rd,
   output logic                    out_reg_write,
   output logic [WIDTH-1:0]        out_result,
   output logic [REG_ID_WIDTH-1:0] fwd_rd,
   output logic                    fwd_data_ready,
   output logic [WIDTH-1:0]        fwd_data,
   output logic                    busy
);

   localparam int ShiftWidth = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StIter, StFixup} stateType;

   typedef enum logic [3:0] {
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSlt, OpSltu, OpSll,
      OpSrl, OpSra, OpMul, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu
   } opType;

   stateType state, nextState;
   opType    inOp, pendOp;

   logic [ShiftWidth-1:0]   counter;
   logic [REG_ID_WIDTH-1:0] pendRd;
   logic                    pendRegWrite;
   logic [31:0]             pendPc, pendInstruction;
   logic [WIDTH-1:0]        pendA;
   logic                    negQuot, negRem, divZero;

   // Multiply: accumulator, left-shifting multiplicand, right-shifting multiplier.
   // Divide: remainder/quotient pair; operandB doubles as the divisor magnitude.
   logic [2*WIDTH-1:0] prodAcc, multiplicand;
   logic [WIDTH-1:0]   operandB, remainder, quotient;

   logic             accept, inMulti, inSignedDiv, inDivOp, aNeg, bNeg, pendIsMul, iterDone;
   logic [WIDTH-1:0] aMag, bMag, aluResult, fixResult, remNext;
   logic [WIDTH:0]   remShift;
   logic             canSub;
   logic [ShiftWidth-1:0] shamt;

   assign inOp        = opType'(in_op);
   assign accept      = in_valid && in_ready;
   assign inMulti     = (in_op >= 4'd10);
   assign inDivOp     = (in_op >= 4'd12);
   assign inSignedDiv = (inOp == OpDiv) || (inOp == OpRem);
   assign aNeg        = inSignedDiv && in_a[WIDTH-1];
   assign bNeg        = inSignedDiv && in_b[WIDTH-1];
   assign aMag        = aNeg ? (~in_a + 1'b1) : in_a;
   assign bMag        = bNeg ? (~in_b + 1'b1) : in_b;
   assign pendIsMul   = (pendOp == OpMul) || (pendOp == OpMulhu);
   assign shamt       = in_b[ShiftWidth-1:0];

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   assign remShift = {remainder, quotient[WIDTH-1]};
   assign canSub   = (remShift >= {1'b0, operandB});
   always_comb begin
      // NOTE: every variable written in a combinational block gets a default first,
      // so no path through the block leaves it unassigned and infers a latch.
      remNext = remShift[WIDTH-1:0];
      if (canSub) begin
         remNext = remShift[WIDTH-1:0] - operandB;
      end
   end

`ifdef MULDIV_EARLY_OUT_EN
   assign iterDone = (counter == ShiftWidth'(WIDTH - 1)) ||
                     (pendIsMul && ((operandB >> 1) == '0));
`else
   assign iterDone = (counter == ShiftWidth'(WIDTH - 1));
`endif

   // Single-cycle ALU result for the op currently offered upstream.
   always_comb begin
      aluResult = '0;
      case (inOp)
         OpAdd:  aluResult = in_a + in_b;
         OpSub:  aluResult = in_a - in_b;
         OpAnd:  aluResult = in_a & in_b;
         OpOr:   aluResult = in_a | in_b;
         OpXor:  aluResult = in_a ^ in_b;
         OpSlt:  aluResult = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
         OpSltu: aluResult = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
         OpSll:  aluResult = in_a << shamt;
         OpSrl:  aluResult = in_a >> shamt;
         OpSra:  aluResult = WIDTH'($signed(in_a) >>> shamt);
         default: aluResult = '0;
      endcase
   end

   // Final muldiv result: pick product half, apply sign and divide-by-zero rules.
   always_comb begin
      fixResult = '0;
      case (pendOp)
         OpMul:          fixResult = prodAcc[WIDTH-1:0];
         OpMulhu:        fixResult = prodAcc[2*WIDTH-1:WIDTH];
         OpDiv, OpDivu:  fixResult = divZero ? '1 : (negQuot ? (~quotient + 1'b1) : quotient);
         OpRem, OpRemu:  fixResult = divZero ? pendA : (negRem ? (~remainder + 1'b1) : remainder);
         default:        fixResult = '0;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset) begin
         state <= StIdle;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; flush overrides everything.
   always_comb begin
      nextState = state;
      case (state)
         StIdle:  if (accept && inMulti) nextState = (inDivOp && in_b == '0) ? StFixup : StIter;
         StIter:  if (iterDone) nextState = StFixup;
         StFixup: nextState = StIdle;
         default: nextState = StIdle;
      endcase
      if (flush) nextState = StIdle;
   end

   // Output logic: handshake, busy flag and forwarding record.
   always_comb begin
      busy           = (state != StIdle);
      in_ready       = reset && !flush && (state == StIdle) && (!out_valid || out_ready);
      fwd_rd         = '0;
      fwd_data_ready = 1'b1;
      fwd_data       = '0;
      if (busy && pendRegWrite) begin
         fwd_rd         = pendRd;
         fwd_data_ready = 1'b0;
      end else if (out_valid && out_reg_write) begin
         fwd_rd   = out_rd;
         fwd_data = out_result;
      end
   end

   // Capture the accepted instruction and step the multiply/divide datapath.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         counter         <= '0;
         pendOp          <= OpAdd;
         pendRd          <= '0;
         pendRegWrite    <= 1'b0;
         pendPc          <= '0;
         pendInstruction <= '0;
         pendA           <= '0;
         negQuot         <= 1'b0;
         negRem          <= 1'b0;
         divZero         <= 1'b0;
         prodAcc         <= '0;
         multiplicand    <= '0;
         operandB        <= '0;
         remainder       <= '0;
         quotient        <= '0;
      end else if (flush) begin
         counter <= '0;
      end else if (accept) begin
         counter         <= '0;
         pendOp          <= inOp;
         pendRd          <= in_rd;
         pendRegWrite    <= in_reg_write;
         pendPc          <= in_pc;
         pendInstruction <= in_instruction;
         pendA           <= in_a;
         negQuot         <= aNeg ^ bNeg;
         negRem          <= aNeg;
         divZero         <= (in_b == '0);
         prodAcc         <= '0;
         multiplicand    <= {{WIDTH{1'b0}}, aMag};
         operandB        <= bMag;
         remainder       <= '0;
         quotient        <= aMag;
      end else if (state == StIter) begin
         counter <= counter + ShiftWidth'(1);
         if (pendIsMul) begin
            if (operandB[0]) prodAcc <= prodAcc + multiplicand;
            multiplicand <= multiplicand << 1;
            operandB     <= operandB >> 1;
         end else begin
            remainder <= remNext;
            quotient  <= {quotient[WIDTH-2:0], canSub};
         end
      end
   end

   // Result register: loads single-cycle results or the FIXUP result, holds under stall.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid       <= 1'b0;
         out_pc          <= '0;
         out_instruction <= '0;
         out_rd          <= '0;
         out_reg_write   <= 1'b0;
         out_result      <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept && !inMulti) begin
         out_valid       <= 1'b1;
         out_pc          <= in_pc;
         out_instruction <= in_instruction;
         out_rd          <= in_rd;
         out_reg_write   <= in_reg_write;
         out_result      <= aluResult;
      end else if (state == StFixup) begin
         out_valid       <= 1'b1;
         out_pc          <= pendPc;
         out_instruction <= pendInstruction;
         out_rd          <= pendRd;
         out_reg_write   <= pendRegWrite;
         out_result      <= fixResult;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
